// File: rtl/btb_update_queue.sv
// BTB write-side update queue: filters resolved branches, coalesces same-PC updates,
// drains one entry per cycle to the BTB write port. Optional stats: BTB_UPD_STATS_EN.
module btb_update_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        res_btb_hit,
    input  logic [31:0] res_pred_target,
    input  logic        wr_stall,
    output logic [31:0] w_pc,
    output logic [31:0] target_in,
    output logic        load,
    output logic        q_full,
    output logic        q_empty,
    output logic        drop
`ifdef BTB_UPD_STATS_EN
    ,
    output logic [15:0] stat_enq,
    output logic [15:0] stat_coal,
    output logic [15:0] stat_drop
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [31:0]   pc_q  [DEPTH];
    logic [31:0]   tgt_q [DEPTH];
    logic [AW-1:0] widx, ridx, tidx;
    logic          need, deq, tail_is_head, coal, enq, drop_d, drop_q;

    assign widx = wptr_q[AW-1:0];
    assign ridx = rptr_q[AW-1:0];
    assign tidx = widx - AW'(1);

    assign q_empty   = (wptr_q == rptr_q);
    assign q_full    = (wptr_q[AW] != rptr_q[AW]) && (widx == ridx);
    assign w_pc      = pc_q[ridx];
    assign target_in = tgt_q[ridx];
    assign load      = ~q_empty & ~wr_stall;
    assign deq       = load;
    assign drop      = drop_q;

    assign need = res_valid & res_taken & (~res_btb_hit | (res_pred_target != res_target));

    // A single entry leaving this cycle can't absorb a coalesce; it must re-enqueue.
    assign tail_is_head = ((wptr_q - rptr_q) == (AW+1)'(1));

    always_comb begin
        coal   = 1'b0;
        enq    = 1'b0;
        drop_d = 1'b0;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (need && !q_empty && (pc_q[tidx] == res_pc) && !(tail_is_head && deq))
            coal = 1'b1;
        if (need && !coal) begin
            if (!q_full || deq) enq    = 1'b1;
            else                drop_d = 1'b1;
        end
        if (enq) wptr_d = wptr_q + (AW+1)'(1);
        if (deq) rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            drop_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                tgt_q[i] <= '0;
            end
        end else if (enq) begin
            pc_q[widx]  <= res_pc;
            tgt_q[widx] <= res_target;
        end else if (coal) begin
            tgt_q[tidx] <= res_target;
        end
    end

`ifdef BTB_UPD_STATS_EN
    logic [15:0] enq_cnt_q, coal_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enq_cnt_q  <= '0;
            coal_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (enq    && enq_cnt_q  != 16'hFFFF) enq_cnt_q  <= enq_cnt_q  + 16'd1;
            if (coal   && coal_cnt_q != 16'hFFFF) coal_cnt_q <= coal_cnt_q + 16'd1;
            if (drop_d && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign stat_enq  = enq_cnt_q;
    assign stat_coal = coal_cnt_q;
    assign stat_drop = drop_cnt_q;
`endif

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue: filtering, coalesce, full/drop, wrap, async reset.
module tb_btb_update_queue;
    logic        clk, rst;
    logic        res_valid, res_taken, res_btb_hit, wr_stall;
    logic [31:0] res_pc, res_target, res_pred_target;
    logic [31:0] w_pc, target_in;
    logic        load, q_full, q_empty, drop;
`ifdef BTB_UPD_STATS_EN
    logic [15:0] stat_enq, stat_coal, stat_drop;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] wlog[$];

    btb_update_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
        .res_target(res_target), .res_btb_hit(res_btb_hit),
        .res_pred_target(res_pred_target), .wr_stall(wr_stall),
        .w_pc(w_pc), .target_in(target_in), .load(load),
        .q_full(q_full), .q_empty(q_empty), .drop(drop)
`ifdef BTB_UPD_STATS_EN
        , .stat_enq(stat_enq), .stat_coal(stat_coal), .stat_drop(stat_drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after posedge; writes are logged mid-cycle at negedge.
    always @(negedge clk) if (load && !rst) wlog.push_back({w_pc, target_in});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                        input logic hit, input logic [31:0] pred);
        res_valid = 1'b1; res_pc = pc; res_target = tgt;
        res_taken = tk; res_btb_hit = hit; res_pred_target = pred;
        tick();
        res_valid = 1'b0; res_pc = '0; res_target = '0;
        res_taken = 1'b0; res_btb_hit = 1'b0; res_pred_target = '0;
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [63:0] exp);
        if (idx < wlog.size()) chk(tag, wlog[idx], exp);
        else chk(tag, 64'hBAD0_BAD0_BAD0_BAD0, exp);
    endtask

    initial begin
        rst = 1'b1; wr_stall = 1'b0;
        res_valid = 1'b0; res_pc = '0; res_target = '0;
        res_taken = 1'b0; res_btb_hit = 1'b0; res_pred_target = '0;
        repeat (2) tick();
        #1;
        chk("rst_empty", q_empty, 1);
        chk("rst_full", q_full, 0);
        chk("rst_load", load, 0);
        chk("rst_drop", drop, 0);
        chk("rst_wpc", w_pc, 0);
        chk("rst_tgt", target_in, 0);
        rst = 1'b0;
        tick();

        // 1: miss update, one cycle latency to load
        push(32'h0000002D, 32'hDEADBEEF, 1, 0, 0);
        #1;
        chk("t1_load", load, 1);
        chk("t1_wpc", w_pc, 32'h0000002D);
        chk("t1_tgt", target_in, 32'hDEADBEEF);
        tick(); #1;
        chk("t1_empty", q_empty, 1);
        chk("t1_load0", load, 0);
        chk("t1_nwr", wlog.size(), 1);
        chk_log("t1_wr", 0, {32'h0000002D, 32'hDEADBEEF});
        wlog.delete();

        // 2: filtering; correct hit and not-taken never enqueue, wrong-target hit does
        push(32'h00000040, 32'h100, 1, 1, 32'h100);
        #1;
        chk("t2_hit_load", load, 0);
        chk("t2_hit_empty", q_empty, 1);
        push(32'h00000010, 32'h200, 0, 0, 0);
        #1;
        chk("t2_nt_empty", q_empty, 1);
        chk("t2_nt_drop", drop, 0);
        push(32'h00000044, 32'h200, 1, 1, 32'h300);
        #1;
        chk("t2_wrong_load", load, 1);
        tick();
        chk("t2_nwr", wlog.size(), 1);
        chk_log("t2_wr", 0, {32'h00000044, 32'h200});
        wlog.delete();

        // 3: coalesce while stalled
        wr_stall = 1'b1;
        push(32'h1000002D, 32'hFEEBFEEB, 1, 0, 0);
        push(32'h1000002D, 32'h00BADBAD, 1, 1, 32'hFEEBFEEB);
        #1;
        chk("t3_load_stall", load, 0);
        chk("t3_empty", q_empty, 0);
        chk("t3_wpc", w_pc, 32'h1000002D);
        chk("t3_tgt", target_in, 32'h00BADBAD);
        wr_stall = 1'b0;
        #1;
        chk("t3_load", load, 1);
        tick(); #1;
        chk("t3_empty_after", q_empty, 1);
        chk("t3_nwr", wlog.size(), 1);
        chk_log("t3_wr", 0, {32'h1000002D, 32'h00BADBAD});
        wlog.delete();

        // 4+5: fill, drop, then simultaneous enqueue/dequeue on a full queue
        wr_stall = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h10 + 4*i, 32'h110 + 4*i, 1, 0, 0);
        #1;
        chk("t4_full", q_full, 1);
        chk("t4_drop_pre", drop, 0);
        push(32'h20, 32'h120, 1, 0, 0);
        #1;
        chk("t4_drop", drop, 1);
        chk("t4_full2", q_full, 1);
        tick(); #1;
        chk("t4_drop_pulse", drop, 0);
        wr_stall = 1'b0;
        push(32'h24, 32'h124, 1, 0, 0);
        #1;
        chk("t5_full", q_full, 1);
        chk("t5_drop", drop, 0);
        chk("t5_head", w_pc, 32'h14);
        repeat (6) tick();
        chk("t5_empty", q_empty, 1);
        chk("t5_nwr", wlog.size(), 5);
        for (int i = 0; i < 4; i++)
            chk_log("t4_order", i, {32'h10 + 32'(4*i), 32'h110 + 32'(4*i)});
        chk_log("t5_new", 4, {32'h24, 32'h124});
        wlog.delete();

        // same PC while the single entry drains must become a new entry
        push(32'h50, 32'h1, 1, 0, 0);
        push(32'h50, 32'h2, 1, 0, 0);
        repeat (3) tick();
        chk("tx_nwr", wlog.size(), 2);
        chk_log("tx_wr0", 0, {32'h50, 32'h1});
        chk_log("tx_wr1", 1, {32'h50, 32'h2});
        wlog.delete();
`ifdef BTB_UPD_STATS_EN
        chk("st_enq", stat_enq, 10);
        chk("st_coal", stat_coal, 1);
        chk("st_drop", stat_drop, 1);
`endif

        // 6: async reset with pending entries
        wr_stall = 1'b1;
        push(32'h30, 32'h130, 1, 0, 0);
        push(32'h34, 32'h134, 1, 0, 0);
        push(32'h38, 32'h138, 1, 0, 0);
        #1;
        chk("t6_pending", q_empty, 0);
        wr_stall = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_load", load, 0);
        chk("t6_empty", q_empty, 1);
        chk("t6_wpc", w_pc, 0);
        chk("t6_full", q_full, 0);
`ifdef BTB_UPD_STATS_EN
        chk("t6_st_enq", stat_enq, 0);
        chk("t6_st_coal", stat_coal, 0);
        chk("t6_st_drop", stat_drop, 0);
`endif
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("t6_nwr", wlog.size(), 0);
        chk("t6_empty_after", q_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
